// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register dump/load controller: default sizes,
// transfer mode encoding and FSM state encoding, so the processor top and
// the testbench agree on them.
package reg_dump_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH         = 8;
  localparam int DEFAULT_REGISTER_ADDR_BITS = 2;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_RECV  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register file dump/load controller. Dump mode reads registers 0..N-1 and
// streams them out over a valid/ready port; load mode accepts a stream of
// words and writes them into registers 0..N-1. The CPU is held halted while
// this block owns the register file ports.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int REGISTER_ADDR_BITS = DEFAULT_REGISTER_ADDR_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  output logic                          busy,
  output logic                          done,
  output logic                          cpu_halt,
  output logic [REGISTER_ADDR_BITS-1:0] rf_a_select,
  input  logic [DATA_WIDTH-1:0]         rf_a_data,
  output logic [DATA_WIDTH-1:0]         rf_data,
  output logic [REGISTER_ADDR_BITS-1:0] rf_dest_select,
  output logic                          rf_load_enable,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready
);

  // Last register index, decoded explicitly so idx never has to wrap.
  localparam logic [REGISTER_ADDR_BITS-1:0] LAST_IDX = {REGISTER_ADDR_BITS{1'b1}};

  state_t                          state, state_n;
  logic [REGISTER_ADDR_BITS-1:0]   idx, idx_n;
  logic [DATA_WIDTH-1:0]           out_data_n, rf_data_n;
  logic [REGISTER_ADDR_BITS-1:0]   rf_dest_select_n;
  logic                            out_valid_n, in_ready_n, rf_load_enable_n;
  logic                            busy_n, done_n;

  assign rf_a_select = idx;
  assign cpu_halt    = busy;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missing default would infer a latch.
    state_n          = state;
    idx_n            = idx;
    out_data_n       = out_data;
    out_valid_n      = out_valid;
    in_ready_n       = in_ready;
    rf_data_n        = rf_data;
    rf_dest_select_n = rf_dest_select;
    rf_load_enable_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          idx_n = '0;
          if (mode == MODE_LOAD) begin
            in_ready_n = 1'b1;
            state_n    = ST_RECV;
          end else begin
            state_n = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        out_data_n  = rf_a_data;
        out_valid_n = 1'b1;
        state_n     = ST_SEND;
      end
      ST_SEND: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          if (idx == LAST_IDX) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = ST_FETCH;
          end
        end
      end
      ST_RECV: begin
        if (in_valid && in_ready) begin
          rf_data_n        = in_data;
          rf_dest_select_n = idx;
          rf_load_enable_n = 1'b1;
          in_ready_n       = 1'b0;
          state_n          = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The register file captures rf_data on the edge leaving this state.
        if (idx == LAST_IDX) begin
          state_n = ST_DONE;
        end else begin
          idx_n      = idx + 1'b1;
          in_ready_n = 1'b1;
          state_n    = ST_RECV;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

  // State, index and registered outputs; reset clears rf_load_enable at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      in_ready       <= 1'b0;
      rf_data        <= '0;
      rf_dest_select <= '0;
      rf_load_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state          <= state_n;
      idx            <= idx_n;
      out_data       <= out_data_n;
      out_valid      <= out_valid_n;
      in_ready       <= in_ready_n;
      rf_data        <= rf_data_n;
      rf_dest_select <= rf_dest_select_n;
      rf_load_enable <= rf_load_enable_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed testbench for reg_dump_ctrl with a small behavioural register
// file attached to its read and write ports.
module tb_reg_dump_ctrl;
  import reg_dump_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, mode;
  logic          busy, done, cpu_halt;
  logic [AW-1:0] rf_a_select;
  logic [DW-1:0] rf_a_data;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] rf_dest_select;
  logic          rf_load_enable;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;

  // Bench register file plus a side port used to preload it.
  logic [DW-1:0] regs [4];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            we_count = 0;

  int checks = 0;
  int errors = 0;

  reg_dump_ctrl #(.DATA_WIDTH(DW), .REGISTER_ADDR_BITS(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .cpu_halt(cpu_halt),
    .rf_a_select(rf_a_select), .rf_a_data(rf_a_data),
    .rf_data(rf_data), .rf_dest_select(rf_dest_select),
    .rf_load_enable(rf_load_enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  assign rf_a_data = regs[rf_a_select];

  // Register file write port and write-pulse counter.
  always @(posedge clk) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    else if (rf_load_enable) regs[rf_dest_select] <= rf_data;
    if (rf_load_enable) we_count <= we_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return {6'd0, busy, done, cpu_halt, rf_a_select, rf_data, rf_dest_select,
            rf_load_enable, out_data, out_valid, in_ready};
  endfunction

  // Full dump with optional out_ready stall on word stall_k and optional
  // start pulse during word pulse_k.
  task automatic run_dump(input logic [DW-1:0] e0, e1, e2, e3,
                          input int stall_k, input int stall_n,
                          input int pulse_k, input string tag);
    logic [DW-1:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    start = 1'b1; mode = MODE_DUMP; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    check({tag, " cpu_halt after start"}, cpu_halt, 1);
    check({tag, " valid in fetch"}, out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("%s w%0d valid", tag, k), out_valid, 1);
      check($sformatf("%s w%0d data", tag, k), out_data, exp[k]);
      check($sformatf("%s w%0d select", tag, k), rf_a_select, k);
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("%s stall%0d valid", tag, s), out_valid, 1);
          check($sformatf("%s stall%0d data", tag, s), out_data, exp[k]);
        end
        out_ready = 1'b1;
      end
      if (k == pulse_k) begin
        start = 1'b1; mode = MODE_LOAD;
      end
      tick();
      start = 1'b0; mode = MODE_DUMP;
      check($sformatf("%s w%0d valid drop", tag, k), out_valid, 0);
      check($sformatf("%s w%0d done", tag, k), done, (k == 3) ? 1 : 0);
      check($sformatf("%s w%0d busy", tag, k), busy, 1);
    end
    tick();
    check({tag, " done pulse end"}, done, 0);
    check({tag, " busy end"}, busy, 0);
    check({tag, " halt end"}, cpu_halt, 0);
    tick();
    check({tag, " idle stays"}, {busy, done, out_valid, in_ready}, 0);
  endtask

  // Full load; with gap set, in_valid sits low for two cycles before each word.
  task automatic run_load(input logic [DW-1:0] d0, d1, d2, d3,
                          input bit gap, input string tag);
    logic [DW-1:0] d [4];
    int wc0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    wc0 = we_count;
    start = 1'b1; mode = MODE_LOAD;
    tick();
    start = 1'b0; mode = MODE_DUMP;
    check({tag, " in_ready after start"}, in_ready, 1);
    check({tag, " busy after start"}, busy, 1);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick(); tick();
        check($sformatf("%s gap%0d ready", tag, k), in_ready, 1);
        check($sformatf("%s gap%0d we", tag, k), rf_load_enable, 0);
      end
      in_valid = 1'b1; in_data = d[k];
      tick();
      if (gap) in_valid = 1'b0;
      check($sformatf("%s w%0d we", tag, k), rf_load_enable, 1);
      check($sformatf("%s w%0d dest", tag, k), rf_dest_select, k);
      check($sformatf("%s w%0d wdata", tag, k), rf_data, d[k]);
      check($sformatf("%s w%0d ready in write", tag, k), in_ready, 0);
      tick();
      check($sformatf("%s w%0d we drop", tag, k), rf_load_enable, 0);
      check($sformatf("%s w%0d reg", tag, k), regs[k], d[k]);
      check($sformatf("%s w%0d ready", tag, k), in_ready, (k == 3) ? 0 : 1);
      check($sformatf("%s w%0d done", tag, k), done, (k == 3) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick();
    check({tag, " done end"}, done, 0);
    check({tag, " busy end"}, busy, 0);
    check({tag, " write pulses"}, we_count - wc0, 4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    in_data = '0; in_valid = 1'b0;
    #2;
    check("reset outputs", all_outputs(), 0);
    tick(); tick();
    reset = 1'b0;
    check("after reset outputs", all_outputs(), 0);

    preload(2'd0, 8'h11);
    preload(2'd1, 8'h22);
    preload(2'd2, 8'h33);
    preload(2'd3, 8'h44);
    check("idle ignores nothing", busy, 0);

    run_dump(8'h11, 8'h22, 8'h33, 8'h44, -1, 0, -1, "dump");
    run_dump(8'h11, 8'h22, 8'h33, 8'h44, 1, 5, -1, "dump_stall");
    run_dump(8'h11, 8'h22, 8'h33, 8'h44, -1, 0, 1, "dump_start");

    run_load(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0, "load");
    run_dump(8'hA0, 8'hA1, 8'hA2, 8'hA3, -1, 0, -1, "dump_loaded");
    run_load(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1, "load_gap");
    run_load(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0, "reload");

    // Reset while word 2 sits in WRITE: no write must reach reg 2.
    start = 1'b1; mode = MODE_LOAD;
    tick();
    start = 1'b0; mode = MODE_DUMP;
    in_valid = 1'b1; in_data = 8'hB0; tick(); tick();
    in_data = 8'hB1; tick(); tick();
    in_data = 8'hB2; tick();
    check("rst pre write we", rf_load_enable, 1);
    check("rst pre write dest", rf_dest_select, 2);
    reset = 1'b1;
    #1;
    check("rst outputs immediate", all_outputs(), 0);
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst outputs held", all_outputs(), 0);
    check("rst reg0", regs[0], 8'hB0);
    check("rst reg1", regs[1], 8'hB1);
    check("rst reg2 unchanged", regs[2], 8'hA2);
    check("rst reg3 unchanged", regs[3], 8'hA3);
    run_dump(8'hB0, 8'hB1, 8'hA2, 8'hA3, -1, 0, -1, "dump_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
